// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM port among N clients.
// Define RSP_REG_EN to add a registered response stage (2-cycle latency).
module rom_rr_arbiter #(
   parameter int N = 4,
   parameter int AW = 4,
   parameter int DW = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N*AW-1:0] req_addr,
   output logic [N-1:0]    gnt,
   output logic            rom_en,
   output logic [AW-1:0]   rom_addr,
   input  logic [DW-1:0]   rom_data,
   output logic            rsp_valid,
   output logic [IDW-1:0]  rsp_id,
   output logic [DW-1:0]   rsp_data,
   input  logic            rsp_ready
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic           found;
   logic           stall;
   logic           issue;

   // First requester at or after ptr, wrapping N-1 -> 0.
   always_comb begin
      int idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   assign issue  = rst_n && found && !stall;
   assign rom_en = issue;

   always_comb begin
      gnt      = '0;
      rom_addr = '0;
      if (issue) begin
         gnt[win] = 1'b1;
         rom_addr = req_addr[int'(win)*AW +: AW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (issue) begin
         ptr <= (int'(win) == N-1) ? '0 : win + 1'b1;
      end
   end

`ifdef RSP_REG_EN
   logic           s1_v;
   logic [IDW-1:0] s1_id;
   logic           adv;

   // The ROM output is stage 1; it only moves when stage 2 can take it.
   assign adv   = s1_v && (!rsp_valid || rsp_ready);
   assign stall = s1_v && !adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         s1_v <= issue | stall;
         if (issue) s1_id <= win;
         if (adv) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s1_id;
            rsp_data  <= rom_data;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
`else
   // A stalled ROM is not enabled, so its output holds the response data.
   assign stall    = rsp_valid && !rsp_ready;
   assign rsp_data = rom_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
      end else begin
         rsp_valid <= issue | stall;
         if (issue) rsp_id <= win;
      end
   end
`endif

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter with a behavioural synchronous ROM.
// Response latency follows RSP_REG_EN.
module tb_rom_rr_arbiter;
   localparam int N = 4;
   localparam int AW = 4;
   localparam int DW = 4;
`ifdef RSP_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int HID = (LAT == 1) ? 2 : 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt;
   logic            rom_en;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_data;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [DW-1:0]   rsp_data;
   logic            rsp_ready;

   int n_chk = 0;
   int n_fail = 0;

   rom_rr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
      .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return DW'(a * 3 + 5);
   endfunction

   always @(posedge clk) if (rom_en) rom_data <= rom_f(rom_addr);

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 4'hF;
      req_addr  = '0;
      rsp_ready = 1'b1;
      // reset hold
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 16'(gnt), 16'h0);
      chk("rst_en", 16'(rom_en), 16'h0);
      chk("rst_addr", 16'(rom_addr), 16'h0);
      chk("rst_vld", 16'(rsp_valid), 16'h0);
      rst_n = 1'b1;
      #1;
      chk("first_gnt", 16'(gnt), 16'h1);
      req = 4'h0;
      step;

      // single request
      req = 4'b0001;
      req_addr[3:0] = 4'hA;
      #1;
      chk("s_gnt", 16'(gnt), 16'h1);
      chk("s_en", 16'(rom_en), 16'h1);
      chk("s_addr", 16'(rom_addr), 16'hA);
      step;
      req = 4'h0;
      if (LAT == 2) step;
      chk("s_vld", 16'(rsp_valid), 16'h1);
      chk("s_id", 16'(rsp_id), 16'h0);
      chk("s_data", 16'(rsp_data), 16'(rom_f(4'hA)));
      step;
      chk("s_idle", 16'(rsp_valid), 16'h0);

      // bring ptr back to 0
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;

      // round robin, all requesting
      req_addr = 16'h4321;
      for (int k = 0; k < 8 + LAT; k++) begin
         req = (k < 8) ? 4'hF : 4'h0;
         #1;
         if (k < 8) chk("rr_gnt", 16'(gnt), 16'(1 << (k % 4)));
         if (k >= LAT) begin
            chk("rr_vld", 16'(rsp_valid), 16'h1);
            chk("rr_id", 16'(rsp_id), 16'((k - LAT) % 4));
            chk("rr_data", 16'(rsp_data),
                16'(rom_f(AW'((k - LAT) % 4 + 1))));
         end
         step;
      end
      chk("rr_idle", 16'(rsp_valid), 16'h0);

      // backpressure, ptr = 0
      req_addr = 16'h0CB0;
      for (int k = 0; k < 8; k++) begin
         rsp_ready = !(k >= 2 && k <= 5);
         req = 4'b0110;
         #1;
         if (k == 0 || k == 6) chk("bp_gnt1", 16'(gnt), 16'h2);
         if (k == 1 || k == 7) chk("bp_gnt2", 16'(gnt), 16'h4);
         if (k >= 2 && k <= 5) begin
            chk("bp_stall_gnt", 16'(gnt), 16'h0);
            chk("bp_stall_en", 16'(rom_en), 16'h0);
            chk("bp_hold_vld", 16'(rsp_valid), 16'h1);
            chk("bp_hold_id", 16'(rsp_id), 16'(HID));
            chk("bp_hold_data", 16'(rsp_data),
                16'(rom_f((HID == 1) ? 4'hB : 4'hC)));
         end
         if (k == 6) chk("bp_res_id", 16'(rsp_id), 16'(HID));
         if (k == 7) chk("bp_next_id", 16'(rsp_id), 16'(3 - HID));
         step;
      end
      req = 4'h0;
      repeat (LAT + 1) step;
      chk("bp_idle", 16'(rsp_valid), 16'h0);

      // wrap and skip, ptr = 3
      req_addr = 16'h0C07;
      for (int k = 0; k < LAT + 2; k++) begin
         req = (k < 2) ? 4'b0101 : 4'h0;
         #1;
         if (k == 0) begin
            chk("w_gnt0", 16'(gnt), 16'h1);
            chk("w_addr0", 16'(rom_addr), 16'h7);
         end
         if (k == 1) begin
            chk("w_gnt2", 16'(gnt), 16'h4);
            chk("w_addr2", 16'(rom_addr), 16'hC);
         end
         if (k == LAT) begin
            chk("w_id0", 16'(rsp_id), 16'h0);
            chk("w_d0", 16'(rsp_data), 16'(rom_f(4'h7)));
         end
         if (k == LAT + 1) begin
            chk("w_id2", 16'(rsp_id), 16'h2);
            chk("w_d2", 16'(rsp_data), 16'(rom_f(4'hC)));
         end
         step;
      end

      // async reset mid-burst
      req = 4'hF;
      req_addr = 16'h4321;
      repeat (LAT + 1) step;
      chk("ar_busy", 16'(rsp_valid), 16'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_vld", 16'(rsp_valid), 16'h0);
      chk("ar_id", 16'(rsp_id), 16'h0);
      chk("ar_gnt", 16'(gnt), 16'h0);
      chk("ar_en", 16'(rom_en), 16'h0);
      rst_n = 1'b1;
      #1;
      chk("ar_ptr", 16'(gnt), 16'h1);
      req = 4'h0;
      for (int k = 0; k < 2; k++) begin
         step;
         chk("ar_stale", 16'(rsp_valid), 16'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
